// File: rtl/avalon_tcm_responder_if.sv
// Avalon-MM request/response bundle between an initiator and one TCM responder port.
// The initiator drives the request fields; the responder drives waitrequest and the response strobes.
interface avalon_tcm_responder_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              writeresponsevalid;
  logic [1:0]        response;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/avalon_tcm_responder.sv
// Avalon-MM responder around a word-addressed RAM: fixed LATENCY-cycle, in-order responses.
// Backpressure: waitrequest rises only from reset or MAX_PEND requests outstanding, never from read/write.
module avalon_tcm_responder #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 2,
  parameter int MAX_PEND = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  avalon_tcm_responder_if.slave avalon_s
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W   = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        vld;
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] dat;
  } stg_t;

  logic [31:0]      mem [DEPTH];
  stg_t             stg_q [LATENCY];
  stg_t             req_d;
  logic [CNT_W-1:0] count_q;
  logic             wait_int;
  logic             acc;
  logic             in_range;
  logic             wr_en;
  logic             launch;
  logic [IDX_W-1:0] idx;

  assign wait_int = rst_i | (count_q == CNT_MAX);
  assign acc      = (avalon_s.read | avalon_s.write) & ~wait_int;
  assign in_range = {1'b0, avalon_s.address} < DEPTH_A;
  assign idx      = avalon_s.address[IDX_W-1:0];
  assign wr_en    = acc & avalon_s.write & ~avalon_s.read & in_range;

  // Non-accepted cycles load an all-zero stage so idle outputs read back as zero.
  always_comb begin
    req_d = '0;
    if (acc) begin
      req_d.vld = 1'b1;
      if (avalon_s.read && avalon_s.write) begin
        req_d.is_wr = 1'b1;
        req_d.resp  = RESP_DECERR;
      end else if (!in_range) begin
        req_d.is_wr = avalon_s.write;
        req_d.resp  = RESP_SLVERR;
      end else begin
        req_d.is_wr = avalon_s.write;
        req_d.resp  = RESP_OKAY;
        if (avalon_s.read) begin
          req_d.dat = mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (avalon_s.byteenable[i]) begin
          mem[idx][8*i +: 8] <= avalon_s.writedata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= req_d;
      for (int i = 1; i < LATENCY; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  // A request stops counting as pending once it moves into the output stage,
  // which lets MAX_PEND == LATENCY sustain one acceptance per cycle.
  generate
    if (LATENCY == 1) begin : g_launch_l1
      assign launch = acc;
    end else begin : g_launch_ln
      assign launch = stg_q[LATENCY-2].vld;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (acc && !launch) begin
      count_q <= count_q + 1'b1;
    end else if (!acc && launch) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign avalon_s.waitrequest        = wait_int;
  assign avalon_s.readdatavalid      = stg_q[LATENCY-1].vld & ~stg_q[LATENCY-1].is_wr;
  assign avalon_s.writeresponsevalid = stg_q[LATENCY-1].vld &  stg_q[LATENCY-1].is_wr;
  assign avalon_s.response           = stg_q[LATENCY-1].resp;
  assign avalon_s.readdata           = stg_q[LATENCY-1].dat;

endmodule

// File: tb/tb_avalon_tcm_responder.sv
// Bench for avalon_tcm_responder: two configurations (L=2/P=2 and L=3/P=1) share one request stream,
// each checked every cycle against a queue-based model plus directed literal expectations.
module tb_avalon_tcm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_rd, st_wr;
  logic [3:0]  st_be;
  logic [11:0] st_addr;
  logic [31:0] st_wd;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          due;
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] dat;
    bit          known;
  } exp_t;

  typedef struct {
    int          cyc;
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] dat;
  } log_t;

  log_t log0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int L = (g == 0) ? 2 : 3;
      localparam int P = (g == 0) ? 2 : 1;

      avalon_tcm_responder_if #(.ADDR_W(12)) bus ();

      assign bus.address    = st_addr;
      assign bus.byteenable = st_be;
      assign bus.read       = st_rd;
      assign bus.write      = st_wr;
      assign bus.writedata  = st_wd;

      avalon_tcm_responder #(
        .ADDR_W(12), .DEPTH(1024), .LATENCY(L), .MAX_PEND(P)
      ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .avalon_s(bus)
      );

      logic [31:0] mem_m [1024];
      logic [3:0]  kn    [1024];
      exp_t        q[$];
      int          hist[$];
      int          acc_n = 0;
      int          wait_n = 0;

      initial for (int i = 0; i < 1024; i++) kn[i] = 4'h0;

      always @(negedge clk) if (cyc >= 1) begin : model
        exp_t e;
        bit   have;
        bit   wexp;
        // Pending = accepted in the previous L-1 cycles (older ones are already answered).
        while (hist.size() > 0 && hist[0] <= cyc - L) void'(hist.pop_front());
        wexp = rst || (hist.size() == P);
        have = (q.size() > 0) && (q[0].due == cyc);
        if (have) e = q.pop_front();
        else begin
          e.due = 0; e.is_wr = 0; e.resp = 2'b00; e.dat = 32'h0; e.known = 1;
        end
        chk($sformatf("c%0d_waitrequest", g), bus.waitrequest, wexp);
        chk($sformatf("c%0d_readdatavalid", g), bus.readdatavalid, have && !e.is_wr);
        chk($sformatf("c%0d_wrespvalid", g), bus.writeresponsevalid, have && e.is_wr);
        chk($sformatf("c%0d_response", g), bus.response, e.resp);
        if (e.known) chk($sformatf("c%0d_readdata", g), bus.readdata, e.dat);
        chk($sformatf("c%0d_count_max", g), dut.count_q <= P, 1'b1);
        if (g == 0 && (bus.readdatavalid || bus.writeresponsevalid))
          log0.push_back('{cyc, bus.writeresponsevalid, bus.response, bus.readdata});

        if (rst) begin
          q.delete();
          hist.delete();
        end else if (st_rd || st_wr) begin
          if (wexp) wait_n++;
          else begin
            acc_n++;
            hist.push_back(cyc);
            e.due = cyc + L; e.known = 1; e.dat = 32'h0; e.resp = 2'b00;
            if (st_rd && st_wr) begin
              e.is_wr = 1; e.resp = 2'b11;
            end else if (st_addr >= 12'd1024) begin
              e.is_wr = st_wr; e.resp = 2'b10;
            end else if (st_rd) begin
              e.is_wr = 0;
              e.dat   = mem_m[st_addr[9:0]];
              e.known = (kn[st_addr[9:0]] == 4'hF);
            end else begin
              e.is_wr = 1;
              for (int b = 0; b < 4; b++) if (st_be[b]) begin
                mem_m[st_addr[9:0]][8*b +: 8] = st_wd[8*b +: 8];
                kn[st_addr[9:0]][b] = 1'b1;
              end
            end
            q.push_back(e);
          end
        end
      end
    end
  endgenerate

  task automatic do_req(input bit rd, input bit wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int t);
    @(posedge clk); #1;
    st_rd = rd; st_wr = wr; st_addr = a; st_be = be; st_wd = d;
    t = cyc;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    st_rd = 0; st_wr = 0; st_addr = '0; st_be = '0; st_wd = '0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic expect_resp(input string nm, input int c, input bit is_wr,
                             input logic [1:0] resp, input logic [31:0] dat);
    logic [35:0] act;
    act = '0;
    foreach (log0[i]) if (log0[i].cyc == c) act = {1'b1, log0[i].is_wr, log0[i].resp, log0[i].dat};
    chk(nm, act, {1'b1, is_wr, resp, dat});
  endtask

  initial begin
    int t, t1, t0, a0, w0, n;
    rst = 1; st_rd = 1; st_wr = 0; st_addr = 12'h010; st_be = '0; st_wd = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_waitrequest", cfg[0].bus.waitrequest, 1'b1);
      chk("rst_strobes", {cfg[0].bus.readdatavalid, cfg[0].bus.writeresponsevalid}, 2'b00);
    end
    @(posedge clk); #1;
    rst = 0; st_rd = 0;
    @(negedge clk);
    chk("rel_waitrequest", cfg[0].bus.waitrequest, 1'b0);
    chk("rel_count", cfg[0].dut.count_q, 0);
    chk("rel_count_c1", cfg[1].dut.count_q, 0);

    do_req(0, 1, 12'h010, 4'hF, 32'hDEADBEEF, t);
    do_req(1, 0, 12'h010, 4'h0, 32'h0, t1);
    idle(5);
    expect_resp("raw_wresp", t + 2, 1, 2'b00, 32'h0);
    expect_resp("raw_rdata", t + 3, 0, 2'b00, 32'hDEADBEEF);

    do_req(0, 1, 12'h020, 4'hF, 32'h11223344, t);
    do_req(0, 1, 12'h020, 4'b0101, 32'hAABBCCDD, t);
    do_req(1, 0, 12'h020, 4'h0, 32'h0, t);
    idle(5);
    expect_resp("byte_lanes", t + 2, 0, 2'b00, 32'h11BB33DD);

    for (int i = 0; i < 16; i++) do_req(0, 1, 12'(i), 4'hF, 32'hC0DE0000 + 32'(i * 7), t);
    idle(5);
    w0 = cfg[0].wait_n;
    for (int i = 0; i < 16; i++) begin
      do_req(1, 0, 12'(i), 4'h0, 32'h0, t);
      if (i == 0) t0 = t;
    end
    idle(5);
    chk("b2b_no_wait", cfg[0].wait_n - w0, 0);
    for (int i = 0; i < 16; i++)
      expect_resp($sformatf("b2b_rd%0d", i), t0 + 2 + i, 0, 2'b00, 32'hC0DE0000 + 32'(i * 7));

    a0 = cfg[1].acc_n; w0 = cfg[1].wait_n;
    repeat (9) do_req(1, 0, 12'h005, 4'h0, 32'h0, t);
    idle(5);
    chk("thr_c1_accepts", cfg[1].acc_n - a0, 3);
    chk("thr_c1_waits", cfg[1].wait_n - w0, 6);

    do_req(1, 0, 12'h400, 4'h0, 32'h0, t0);
    do_req(0, 1, 12'h400, 4'hF, 32'h12345678, t1);
    do_req(1, 0, 12'h000, 4'h0, 32'h0, t);
    idle(5);
    expect_resp("oor_read", t0 + 2, 0, 2'b10, 32'h0);
    expect_resp("oor_write", t1 + 2, 1, 2'b10, 32'h0);
    expect_resp("oor_no_alias", t + 2, 0, 2'b00, 32'hC0DE0000);

    do_req(0, 1, 12'h030, 4'hF, 32'h0BADF00D, t);
    do_req(1, 1, 12'h030, 4'hF, 32'hFFFFFFFF, t0);
    do_req(1, 0, 12'h030, 4'h0, 32'h0, t1);
    idle(5);
    expect_resp("rdwr_decerr", t0 + 2, 1, 2'b11, 32'h0);
    expect_resp("rdwr_no_effect", t1 + 2, 0, 2'b00, 32'h0BADF00D);

    do_req(0, 1, 12'h040, 4'hF, 32'h5A5A5A5A, t);
    do_req(1, 0, 12'h010, 4'h0, 32'h0, t1);
    @(posedge clk); #1;
    st_rd = 0; st_wr = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    idle(7);
    expect_resp("pre_rst_wresp", t + 2, 1, 2'b00, 32'h0);
    n = 0;
    foreach (log0[i]) if (log0[i].cyc > t + 2 && log0[i].cyc <= t + 10) n++;
    chk("rst_drops_inflight", n, 0);
    do_req(1, 0, 12'h040, 4'h0, 32'h0, t);
    idle(5);
    expect_resp("rst_keeps_write", t + 2, 0, 2'b00, 32'h5A5A5A5A);

    for (int k = 0; k < 600; k++) begin
      int r;
      logic [11:0] a;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) == 0) a = 12'($urandom_range(1023, 4095));
      else a = 12'($urandom_range(0, 63));
      @(posedge clk); #1;
      rst     = (r < 2);
      st_rd   = (r >= 2 && r < 40) || (r >= 90 && r < 95);
      st_wr   = (r >= 40 && r < 80) || (r >= 90 && r < 95);
      st_addr = a;
      st_be   = 4'($urandom_range(0, 15));
      st_wd   = $urandom;
    end
    @(posedge clk); #1;
    rst = 0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
